// File: rtl/wb_stage_rv32i_pkg.sv
// Shared writeback-stage codes: writeback source select, load funct3 values
// and the load-fault rule used by the alignment logic.
package wb_stage_rv32i_pkg;

  // Writeback source select carried down from decode.
  typedef enum logic [1:0] {
    WBSEL_ALU  = 2'b00,
    WBSEL_LOAD = 2'b01,
    WBSEL_PC4  = 2'b10,
    WBSEL_IMM  = 2'b11
  } wbsel_e;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A load faults when it is misaligned for its size or uses a reserved funct3.
  function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] off);
    logic fault;
    case (funct3)
      F3_LB, F3_LBU: fault = 1'b0;
      F3_LH, F3_LHU: fault = off[0];
      F3_LW:         fault = (off != 2'b00);
      default:       fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/wb_stage_rv32i_if.sv
// MEM->WB bundle plus the register-file write port driven by the WB stage.
// slave: the WB stage itself; master: whoever drives the MEM side and
// observes the write port.
interface wb_stage_rv32i_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) ();

  // Pipeline control
  logic                  stall;
  logic                  flush;

  // MEM-stage results
  logic                  mem_valid;
  logic                  mem_rdwrite;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic [1:0]            mem_wbsel;
  logic [2:0]            mem_funct3;
  logic [1:0]            mem_byte_off;
  logic [XLEN-1:0]       mem_alu_result;
  logic [XLEN-1:0]       mem_load_word;
  logic [XLEN-1:0]       mem_pc4;
  logic [XLEN-1:0]       mem_imm;

  // Register file write port and status
  logic                  cu_rdwrite;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_in;
  logic                  wb_valid;
  logic                  load_err;

  modport slave (
    input  stall, flush,
    input  mem_valid, mem_rdwrite, mem_rd_addr, mem_wbsel, mem_funct3, mem_byte_off,
    input  mem_alu_result, mem_load_word, mem_pc4, mem_imm,
    output cu_rdwrite, rd_addr, rd_in, wb_valid, load_err
  );

  modport master (
    output stall, flush,
    output mem_valid, mem_rdwrite, mem_rd_addr, mem_wbsel, mem_funct3, mem_byte_off,
    output mem_alu_result, mem_load_word, mem_pc4, mem_imm,
    input  cu_rdwrite, rd_addr, rd_in, wb_valid, load_err
  );

endinterface

// File: rtl/wb_stage_rv32i_load_align.sv
// Combinational load alignment: picks the byte/half/word addressed by the
// low address bits out of the raw memory word and sign/zero-extends it.
module wb_stage_rv32i_load_align
  import wb_stage_rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extend according to load type.
  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = word[{off[1], 4'b0000} +: 16];
    data     = '0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   data = word;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = '0;
    endcase
    err = load_fault(funct3, off);
  end

endmodule

// File: rtl/wb_stage_rv32i.sv
// MEM/WB pipeline register and writeback mux for the RV32I core. Drives the
// register-file write port purely from registered state and counts retired
// instructions.
module wb_stage_rv32i
  import wb_stage_rv32i_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  wb_stage_rv32i_if.slave  wb,
  output logic [CNT_W-1:0] retire_count
);

  // WB register fields
  logic                  valid_q, valid_d;
  logic                  rdwrite_q, rdwrite_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  wbsel_e                wbsel_q, wbsel_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            byte_off_q, byte_off_d;
  logic [XLEN-1:0]       alu_q, alu_d;
  logic [XLEN-1:0]       load_word_q, load_word_d;
  logic [XLEN-1:0]       pc4_q, pc4_d;
  logic [XLEN-1:0]       imm_q, imm_d;

  logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;

  logic [XLEN-1:0]       load_data;
  logic                  align_err;
  logic                  load_err;
  logic                  retire;
  logic [XLEN-1:0]       wb_data;

  wb_stage_rv32i_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .word  (load_word_q),
    .funct3(funct3_q),
    .off   (byte_off_q),
    .data  (load_data),
    .err   (align_err)
  );

  // Next WB register contents: flush beats stall beats capture.
  always_comb begin
    valid_d     = valid_q;
    rdwrite_d   = rdwrite_q;
    rd_addr_d   = rd_addr_q;
    wbsel_d     = wbsel_q;
    funct3_d    = funct3_q;
    byte_off_d  = byte_off_q;
    alu_d       = alu_q;
    load_word_d = load_word_q;
    pc4_d       = pc4_q;
    imm_d       = imm_q;
    if (wb.flush) begin
      valid_d     = 1'b0;
      rdwrite_d   = 1'b0;
      rd_addr_d   = '0;
      wbsel_d     = WBSEL_ALU;
      funct3_d    = '0;
      byte_off_d  = '0;
      alu_d       = '0;
      load_word_d = '0;
      pc4_d       = '0;
      imm_d       = '0;
    end else if (!wb.stall) begin
      valid_d     = wb.mem_valid;
      rdwrite_d   = wb.mem_rdwrite;
      rd_addr_d   = wb.mem_rd_addr;
      wbsel_d     = wbsel_e'(wb.mem_wbsel);
      funct3_d    = wb.mem_funct3;
      byte_off_d  = wb.mem_byte_off;
      alu_d       = wb.mem_alu_result;
      load_word_d = wb.mem_load_word;
      pc4_d       = wb.mem_pc4;
      imm_d       = wb.mem_imm;
    end
  end

  // WB register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rdwrite_q   <= 1'b0;
      rd_addr_q   <= '0;
      wbsel_q     <= WBSEL_ALU;
      funct3_q    <= '0;
      byte_off_q  <= '0;
      alu_q       <= '0;
      load_word_q <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      rdwrite_q   <= rdwrite_d;
      rd_addr_q   <= rd_addr_d;
      wbsel_q     <= wbsel_d;
      funct3_q    <= funct3_d;
      byte_off_q  <= byte_off_d;
      alu_q       <= alu_d;
      load_word_q <= load_word_d;
      pc4_q       <= pc4_d;
      imm_q       <= imm_d;
    end
  end

  // Writeback mux and write-port outputs, derived from the WB register only.
  always_comb begin
    wb_data = '0;
    unique case (wbsel_q)
      WBSEL_ALU:  wb_data = alu_q;
      WBSEL_LOAD: wb_data = load_data;
      WBSEL_PC4:  wb_data = pc4_q;
      WBSEL_IMM:  wb_data = imm_q;
      default:    wb_data = '0;
    endcase
    load_err      = valid_q & (wbsel_q == WBSEL_LOAD) & align_err;
    wb.wb_valid   = valid_q;
    wb.load_err   = load_err;
    // Bubbles drive a clean zero address/data rather than stale fields.
    wb.rd_addr    = valid_q ? rd_addr_q : '0;
    wb.rd_in      = valid_q ? wb_data : '0;
    wb.cu_rdwrite = valid_q & rdwrite_q & (rd_addr_q != '0) & ~load_err;
  end

  // An instruction retires on the edge it leaves WB without stall, flush or fault.
  always_comb begin
    retire       = valid_q & ~wb.stall & ~wb.flush & ~load_err;
    retire_cnt_d = retire ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
  end

  // Retire counter; wraps naturally at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_count = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_rv32i.sv
// Bench for wb_stage_rv32i: directed scenarios plus a randomized run checked
// against a spec-level model. A second instance with a 3-bit retire counter
// exercises counter wrap under the same stimulus.
module tb_wb_stage_rv32i;

  typedef struct packed {
    logic        valid;
    logic        rdw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] alu;
    logic [31:0] word;
    logic [31:0] pc4;
    logic [31:0] imm;
  } ins_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_stage_rv32i_if #(.XLEN(32), .REG_ADDR_W(5)) if0 ();
  wb_stage_rv32i_if #(.XLEN(32), .REG_ADDR_W(5)) if1 ();

  logic [31:0] cnt0;
  logic [2:0]  cnt1;

  wb_stage_rv32i #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut0 (
    .clock       (clock),
    .reset       (reset),
    .wb          (if0),
    .retire_count(cnt0)
  );

  wb_stage_rv32i #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(3)) dut1 (
    .clock       (clock),
    .reset       (reset),
    .wb          (if1),
    .retire_count(cnt1)
  );

  assign if1.stall          = if0.stall;
  assign if1.flush          = if0.flush;
  assign if1.mem_valid      = if0.mem_valid;
  assign if1.mem_rdwrite    = if0.mem_rdwrite;
  assign if1.mem_rd_addr    = if0.mem_rd_addr;
  assign if1.mem_wbsel      = if0.mem_wbsel;
  assign if1.mem_funct3     = if0.mem_funct3;
  assign if1.mem_byte_off   = if0.mem_byte_off;
  assign if1.mem_alu_result = if0.mem_alu_result;
  assign if1.mem_load_word  = if0.mem_load_word;
  assign if1.mem_pc4        = if0.mem_pc4;
  assign if1.mem_imm        = if0.mem_imm;

  // Stand-in register file fed from the DUT write port.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clock) if (if0.cu_rdwrite) rf[if0.rd_addr] <= if0.rd_in;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ins_t        cur;
  ins_t        slot;
  logic        st, fl;
  logic [31:0] m_cnt;

  // ---------------- reference model ----------------
  function automatic logic [31:0] f_load(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit f_fault(logic [2:0] f3, logic [1:0] off);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && off % 2 == 1) return 1'b1;
    if (f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit e_err();
    return slot.valid && slot.sel == 2'd1 && f_fault(slot.f3, slot.off);
  endfunction

  function automatic bit e_we();
    return slot.valid && slot.rdw && slot.rd != 0 && !e_err();
  endfunction

  function automatic logic [4:0] e_rd();
    return slot.valid ? slot.rd : 5'd0;
  endfunction

  function automatic logic [31:0] e_data();
    if (!slot.valid) return 32'h0;
    case (slot.sel)
      2'd0:    return slot.alu;
      2'd1:    return f_load(slot.word, slot.f3, slot.off);
      2'd2:    return slot.pc4;
      default: return slot.imm;
    endcase
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic drive();
    if0.stall          = st;
    if0.flush          = fl;
    if0.mem_valid      = cur.valid;
    if0.mem_rdwrite    = cur.rdw;
    if0.mem_rd_addr    = cur.rd;
    if0.mem_wbsel      = cur.sel;
    if0.mem_funct3     = cur.f3;
    if0.mem_byte_off   = cur.off;
    if0.mem_alu_result = cur.alu;
    if0.mem_load_word  = cur.word;
    if0.mem_pc4        = cur.pc4;
    if0.mem_imm        = cur.imm;
  endtask

  // One clock: drive, let the edge happen, advance the model, settle.
  task automatic step();
    drive();
    @(posedge clock);
    if (reset) begin
      slot  = '0;
      m_cnt = 0;
    end else begin
      if (slot.valid && !st && !fl && !e_err()) m_cnt = m_cnt + 1;
      if (fl) slot = '0;
      else if (!st) slot = cur;
    end
    #1;
  endtask

  function automatic ins_t mk(logic [4:0] rd, logic [1:0] sel, logic [2:0] f3, logic [1:0] off,
                              logic [31:0] alu, logic [31:0] word);
    ins_t t;
    t = '0;
    t.valid = 1'b1;
    t.rdw   = 1'b1;
    t.rd    = rd;
    t.sel   = sel;
    t.f3    = f3;
    t.off   = off;
    t.alu   = alu;
    t.word  = word;
    t.pc4   = 32'h0000_1004;
    t.imm   = 32'h1234_5000;
    return t;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    st    = 1'b0;
    fl    = 1'b0;
    cur   = mk(5'd3, 2'd0, 3'd0, 2'd0, 32'h55, 32'h0);
    step();
    step();
    n_cmp++; if (if0.cu_rdwrite !== 1'b0) begin n_bad++; $display("FAIL reset cu_rdwrite got=%b exp=0", if0.cu_rdwrite); end
    n_cmp++; if (if0.rd_in !== 32'h0) begin n_bad++; $display("FAIL reset rd_in got=%h exp=0", if0.rd_in); end
    n_cmp++; if (if0.wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset wb_valid got=%b exp=0", if0.wb_valid); end
    n_cmp++; if (cnt0 !== 32'h0) begin n_bad++; $display("FAIL reset retire_count got=%0d exp=0", cnt0); end
    n_cmp++; if (rf[3] !== 32'h0) begin n_bad++; $display("FAIL reset x3 got=%h exp=0", rf[3]); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    cur = mk(5'd1, 2'd0, 3'd0, 2'd0, 32'h0000_00AA, 32'h0);
    step();
    n_cmp++; if (if0.rd_addr !== 5'd1) begin n_bad++; $display("FAIL alu rd_addr got=%0d exp=1", if0.rd_addr); end
    n_cmp++; if (if0.rd_in !== 32'hAA) begin n_bad++; $display("FAIL alu rd_in got=%h exp=000000aa", if0.rd_in); end
    n_cmp++; if (if0.cu_rdwrite !== 1'b1) begin n_bad++; $display("FAIL alu cu_rdwrite got=%b exp=1", if0.cu_rdwrite); end
    cur = '0;
    step();
    n_cmp++; if (rf[1] !== 32'hAA) begin n_bad++; $display("FAIL alu x1 got=%h exp=000000aa", rf[1]); end
    n_cmp++; if (cnt0 !== 32'd1) begin n_bad++; $display("FAIL alu retire_count got=%0d exp=1", cnt0); end
    // PC+4 and LUI sources
    cur = mk(5'd2, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0);
    step();
    n_cmp++; if (if0.rd_in !== 32'h0000_1004) begin n_bad++; $display("FAIL pc4 rd_in got=%h exp=00001004", if0.rd_in); end
    cur = mk(5'd2, 2'd3, 3'd0, 2'd0, 32'h0, 32'h0);
    step();
    n_cmp++; if (if0.rd_in !== 32'h1234_5000) begin n_bad++; $display("FAIL imm rd_in got=%h exp=12345000", if0.rd_in); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  offs[6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] exps[6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                             32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
    for (int i = 0; i < 6; i++) begin
      cur = mk(5'd5, 2'd1, f3s[i], offs[i], 32'h0, 32'h80FF_7F01);
      step();
      n_cmp++;
      if (if0.rd_in !== exps[i] || if0.load_err !== 1'b0 || if0.cu_rdwrite !== 1'b1) begin
        n_bad++;
        $display("FAIL load%0d f3=%0d off=%0d rd_in got=%h exp=%h err=%b we=%b", i, f3s[i], offs[i],
                 if0.rd_in, exps[i], if0.load_err, if0.cu_rdwrite);
      end
    end
    cur = '0;
    step();
  endtask

  task automatic test_x0();
    logic [31:0] c0;
    c0  = cnt0;
    cur = mk(5'd0, 2'd0, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0);
    step();
    n_cmp++; if (if0.cu_rdwrite !== 1'b0) begin n_bad++; $display("FAIL x0 cu_rdwrite got=%b exp=0", if0.cu_rdwrite); end
    cur = '0;
    step();
    n_cmp++; if (rf[0] !== 32'h0) begin n_bad++; $display("FAIL x0 value got=%h exp=0", rf[0]); end
    n_cmp++; if (cnt0 !== c0 + 32'd1) begin n_bad++; $display("FAIL x0 retire_count got=%0d exp=%0d", cnt0, c0 + 1); end
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    cur = mk(5'd7, 2'd0, 3'd0, 2'd0, 32'h0000_1234, 32'h0);
    step();
    c0 = cnt0;
    st = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur = mk(5'(9 + i), 2'd0, 3'd0, 2'd0, $urandom, 32'h0);
      step();
      n_cmp++;
      if (if0.rd_in !== 32'h1234 || if0.rd_addr !== 5'd7 || if0.cu_rdwrite !== 1'b1 || cnt0 !== c0) begin
        n_bad++;
        $display("FAIL stall%0d rd_in=%h rd=%0d we=%b cnt=%0d exp 00001234/7/1/%0d", i, if0.rd_in,
                 if0.rd_addr, if0.cu_rdwrite, cnt0, c0);
      end
    end
    fl = 1'b1;
    step();
    n_cmp++; if (if0.wb_valid !== 1'b0) begin n_bad++; $display("FAIL stallflush wb_valid got=%b exp=0", if0.wb_valid); end
    n_cmp++; if (cnt0 !== c0) begin n_bad++; $display("FAIL stallflush retire_count got=%0d exp=%0d", cnt0, c0); end
    st = 1'b0;
    fl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur = mk(5'(20 + i), 2'd0, 3'd0, 2'd0, 32'(i), 32'h0);
      step();
    end
    cur = '0;
    step();
    n_cmp++; if (cnt0 !== c0 + 32'd3) begin n_bad++; $display("FAIL resume retire_count got=%0d exp=%0d", cnt0, c0 + 3); end
    // Reset arriving while stalled drops the held instruction.
    cur = mk(5'd8, 2'd0, 3'd0, 2'd0, 32'h77, 32'h0);
    step();
    st    = 1'b1;
    reset = 1'b1;
    step();
    n_cmp++;
    if (if0.wb_valid !== 1'b0 || cnt0 !== 32'h0) begin
      n_bad++;
      $display("FAIL resetstall wb_valid=%b cnt=%0d exp 0/0", if0.wb_valid, cnt0);
    end
    reset = 1'b0;
    st    = 1'b0;
    cur   = '0;
    step();
  endtask

  task automatic test_load_err();
    logic [31:0] c0;
    logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd3};
    logic [1:0]  offs[3] = '{2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 3; i++) begin
      c0  = cnt0;
      cur = mk(5'd6, 2'd1, f3s[i], offs[i], 32'h0, 32'hDEAD_BEEF);
      step();
      n_cmp++;
      if (if0.load_err !== 1'b1 || if0.cu_rdwrite !== 1'b0) begin
        n_bad++;
        $display("FAIL lderr%0d err=%b we=%b exp 1/0", i, if0.load_err, if0.cu_rdwrite);
      end
      cur = '0;
      step();
      n_cmp++; if (cnt0 !== c0) begin n_bad++; $display("FAIL lderr%0d retire_count got=%0d exp=%0d", i, cnt0, c0); end
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    cur   = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cur = mk(5'd4, 2'd0, 3'd0, 2'd0, 32'(i), 32'h0);
      step();
    end
    n_cmp++; if (cnt1 !== 3'd7) begin n_bad++; $display("FAIL wrap pre got=%0d exp=7", cnt1); end
    cur = '0;
    step();
    n_cmp++; if (cnt1 !== 3'd0) begin n_bad++; $display("FAIL wrap small got=%0d exp=0", cnt1); end
    n_cmp++; if (cnt0 !== 32'd8) begin n_bad++; $display("FAIL wrap wide got=%0d exp=8", cnt0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cur       = '0;
      cur.valid = ($urandom_range(0, 9) != 0);
      cur.rdw   = ($urandom_range(0, 7) != 0);
      cur.rd    = 5'($urandom_range(0, 31));
      cur.sel   = 2'($urandom_range(0, 3));
      cur.f3    = 3'($urandom_range(0, 7));
      cur.off   = 2'($urandom_range(0, 3));
      cur.alu   = $urandom;
      cur.word  = $urandom;
      cur.pc4   = $urandom;
      cur.imm   = $urandom;
      st        = ($urandom_range(0, 4) == 0);
      fl        = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 59) == 0);
      step();
      n_cmp++; if (if0.wb_valid !== slot.valid) begin n_bad++; $display("FAIL rnd%0d wb_valid got=%b exp=%b", c, if0.wb_valid, slot.valid); end
      n_cmp++; if (if0.load_err !== e_err()) begin n_bad++; $display("FAIL rnd%0d load_err got=%b exp=%b", c, if0.load_err, e_err()); end
      n_cmp++; if (if0.cu_rdwrite !== e_we()) begin n_bad++; $display("FAIL rnd%0d cu_rdwrite got=%b exp=%b", c, if0.cu_rdwrite, e_we()); end
      n_cmp++; if (if0.rd_addr !== e_rd()) begin n_bad++; $display("FAIL rnd%0d rd_addr got=%0d exp=%0d", c, if0.rd_addr, e_rd()); end
      if (!e_err()) begin
        n_cmp++; if (if0.rd_in !== e_data()) begin n_bad++; $display("FAIL rnd%0d rd_in got=%h exp=%h", c, if0.rd_in, e_data()); end
      end
      n_cmp++; if (cnt0 !== m_cnt) begin n_bad++; $display("FAIL rnd%0d retire_count got=%0d exp=%0d", c, cnt0, m_cnt); end
      n_cmp++; if (cnt1 !== m_cnt[2:0]) begin n_bad++; $display("FAIL rnd%0d retire_count3 got=%0d exp=%0d", c, cnt1, m_cnt[2:0]); end
    end
    reset = 1'b0;
    st    = 1'b0;
    fl    = 1'b0;
  endtask

  initial begin
    slot  = '0;
    cur   = '0;
    st    = 1'b0;
    fl    = 1'b0;
    m_cnt = 0;
    test_reset();
    test_alu();
    test_loads();
    test_x0();
    test_stall();
    test_load_err();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
